// File: rtl/id_scan_pkg.sv
// Shared types, character constants and character-class helpers for the id scanner.
package id_scan_pkg;

  typedef enum logic [1:0] {
    ID_IDLE  = 2'd0,
    ID_ALPHA = 2'd1,
    ID_IDNUM = 2'd2
  } id_state_t;

  localparam logic [7:0] CH_LO_A = 8'h61;
  localparam logic [7:0] CH_LO_Z = 8'h7a;
  localparam logic [7:0] CH_UP_A = 8'h41;
  localparam logic [7:0] CH_UP_Z = 8'h5a;
  localparam logic [7:0] CH_D0   = 8'h30;
  localparam logic [7:0] CH_D9   = 8'h39;

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= CH_LO_A) && (c <= CH_LO_Z)) || ((c >= CH_UP_A) && (c <= CH_UP_Z));
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_D0) && (c <= CH_D9);
  endfunction

endpackage

// File: rtl/id_step.sv
// One recognition step of letter+ digit+: next context and match flag for one char.
module id_step
  import id_scan_pkg::*;
(
  input  logic [1:0] cur_state,
  input  logic [7:0] char_in,
  output logic [1:0] next_state,
  output logic       match
);

  // Encoding 3 is never written; it falls through as IDLE.
  always_comb begin
    next_state = ID_IDLE;
    if (is_letter(char_in)) begin
      next_state = ID_ALPHA;
    end else if (is_digit(char_in) &&
                 ((cur_state == ID_ALPHA) || (cur_state == ID_IDNUM))) begin
      next_state = ID_IDNUM;
    end
    match = (next_state == ID_IDNUM);
  end

endmodule

// File: rtl/id_scan_arbiter.sv
// Round-robin arbiter sharing one id_step between NUM_SRC char streams with
// per-source saved context and a single result register.
// Optional feature: define ID_SCAN_MATCH_COUNT_EN for per-source saturating match counters.
module id_scan_arbiter
  import id_scan_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4
`ifdef ID_SCAN_MATCH_COUNT_EN
  , parameter int unsigned CNT_W = 8
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [8*NUM_SRC-1:0]       src_char,
  input  logic [NUM_SRC-1:0]         src_clear,
  output logic [NUM_SRC-1:0]         src_ready,
  output logic                       res_valid,
  output logic [$clog2(NUM_SRC)-1:0] res_src,
  output logic                       res_match,
  input  logic                       res_ready
`ifdef ID_SCAN_MATCH_COUNT_EN
  , output logic [CNT_W*NUM_SRC-1:0] match_cnt
`endif
);

  localparam int unsigned SRC_W = $clog2(NUM_SRC);

  logic [1:0]       ctx [NUM_SRC];
  logic [SRC_W-1:0] rr_ptr;
  logic [NUM_SRC-1:0] eligible;
  logic             slot_free;
  logic             found;
  logic             accept;
  logic [SRC_W-1:0] gnt_idx;
  logic [SRC_W-1:0] gnt_next;
  int unsigned      scan_idx;
  logic [7:0]       gnt_char;
  logic [1:0]       step_next;
  logic             step_match;

  assign eligible  = src_valid & ~src_clear;
  assign slot_free = ~res_valid | res_ready;

  // Round-robin search for the first eligible source starting at rr_ptr.
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    scan_idx = 0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      scan_idx = 32'(rr_ptr) + 32'(k);
      if (scan_idx >= NUM_SRC) begin
        scan_idx = scan_idx - NUM_SRC;
      end
      if (!found && eligible[SRC_W'(scan_idx)]) begin
        found   = 1'b1;
        gnt_idx = SRC_W'(scan_idx);
      end
    end
  end

  // Grant only into a free result slot; at most one ready bit.
  always_comb begin
    accept    = found & slot_free;
    src_ready = '0;
    src_ready[gnt_idx] = accept;
    gnt_next  = (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + SRC_W'(1);
    gnt_char  = src_char[32'(gnt_idx) * 8 +: 8];
  end

  id_step u_step (
    .cur_state  (ctx[gnt_idx]),
    .char_in    (gnt_char),
    .next_state (step_next),
    .match      (step_match)
  );

  // Result register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_src   <= '0;
      res_match <= 1'b0;
      rr_ptr    <= '0;
    end else if (accept) begin
      res_valid <= 1'b1;
      res_src   <= gnt_idx;
      res_match <= step_match;
      rr_ptr    <= gnt_next;
    end else if (slot_free) begin
      res_valid <= 1'b0;
    end
  end

  // Per-source contexts: clear has priority, only the granted source advances.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (reset || src_clear[i]) begin
        ctx[i] <= ID_IDLE;
      end else if (accept && (gnt_idx == SRC_W'(i))) begin
        ctx[i] <= step_next;
      end
    end
  end

`ifdef ID_SCAN_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt [NUM_SRC];

  // Saturating per-source match counters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (reset || src_clear[i]) begin
        cnt[i] <= '0;
      end else if (accept && step_match && (gnt_idx == SRC_W'(i)) && (cnt[i] != '1)) begin
        cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    match_cnt = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      match_cnt[i*CNT_W +: CNT_W] = cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_id_scan_arbiter.sv
// Randomized and directed bench for id_scan_arbiter against a history-based reference model.
module tb_id_scan_arbiter;

  localparam int N = 4;
`ifdef ID_SCAN_MATCH_COUNT_EN
  localparam int CW = 2;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   src_valid;
  logic [8*N-1:0] src_char;
  logic [N-1:0]   src_clear;
  logic [N-1:0]   src_ready;
  logic           res_valid;
  logic [1:0]     res_src;
  logic           res_match;
  logic           res_ready;
`ifdef ID_SCAN_MATCH_COUNT_EN
  logic [CW*N-1:0] match_cnt;
`endif

  id_scan_arbiter #(
    .NUM_SRC(N)
`ifdef ID_SCAN_MATCH_COUNT_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .src_valid (src_valid),
    .src_char  (src_char),
    .src_clear (src_clear),
    .src_ready (src_ready),
    .res_valid (res_valid),
    .res_src   (res_src),
    .res_match (res_match),
    .res_ready (res_ready)
`ifdef ID_SCAN_MATCH_COUNT_EN
    , .match_cnt (match_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: raw char history since last clear, plus arbitration bookkeeping.
  logic [7:0] hist [N][$];
  int         m_rr;
  bit         m_rv;
  int         m_rs;
  bit         m_rm;
  int         m_cnt [N];
  logic [N-1:0] last_ready;

  task automatic tb_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit tb_dig(input logic [7:0] c);
    return c inside {["0":"9"]};
  endfunction

  function automatic bit tb_let(input logic [7:0] c);
    return (c inside {["a":"z"]}) || (c inside {["A":"Z"]});
  endfunction

  // A stream matches when it ends in a digit run immediately preceded by a letter.
  function automatic bit tb_id_match(input logic [7:0] q[$]);
    int j;
    j = q.size() - 1;
    if (j < 0) return 1'b0;
    if (!tb_dig(q[j])) return 1'b0;
    while (j >= 0 && tb_dig(q[j])) j--;
    if (j < 0) return 1'b0;
    return tb_let(q[j]);
  endfunction

  function automatic logic [7:0] rnd_char();
    int r;
    r = $urandom_range(0, 9);
    if (r < 2) return 8'($urandom_range(97, 122));
    if (r < 4) return 8'($urandom_range(65, 90));
    if (r < 7) return 8'($urandom_range(48, 57));
    case ($urandom_range(0, 3))
      0: return " ";
      1: return "_";
      2: return "-";
      default: return ".";
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      hist[i].delete();
      m_cnt[i] = 0;
    end
    m_rr = 0; m_rv = 0; m_rs = 0; m_rm = 0;
  endtask

  // One clock cycle: drive, check the grant, clock, update model, check results.
  task automatic step(input logic rst, input logic [N-1:0] v, input logic [8*N-1:0] chars,
                      input logic [N-1:0] clr, input logic rdy);
    logic [N-1:0] elig;
    logic [N-1:0] exp_rdy;
    int  g;
    bit  free;
    reset = rst; src_valid = v; src_char = chars; src_clear = clr; res_ready = rdy;
    #1;
    elig = v & ~clr;
    free = !m_rv || rdy;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && elig[(m_rr + k) % N]) g = (m_rr + k) % N;
    end
    exp_rdy = '0;
    if (free && g >= 0) exp_rdy[g] = 1'b1;
    last_ready = src_ready;
    if (!rst) tb_check("src_ready", 32'(src_ready), 32'(exp_rdy));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (clr[i]) begin
          hist[i].delete();
          m_cnt[i] = 0;
        end
      end
      if (free && g >= 0) begin
        hist[g].push_back(chars[8*g +: 8]);
        m_rv = 1; m_rs = g; m_rm = tb_id_match(hist[g]);
        m_rr = (g + 1) % N;
`ifdef ID_SCAN_MATCH_COUNT_EN
        if (m_rm && m_cnt[g] < (1 << CW) - 1) m_cnt[g]++;
`endif
      end else if (free) begin
        m_rv = 0;
      end
    end
    #1;
    tb_check("res_valid", 32'(res_valid), 32'(m_rv));
    if (m_rv || rst) begin
      tb_check("res_src", 32'(res_src), 32'(m_rs));
      tb_check("res_match", 32'(res_match), 32'(m_rm));
    end
`ifdef ID_SCAN_MATCH_COUNT_EN
    for (int i = 0; i < N; i++) tb_check("match_cnt", 32'(match_cnt[i*CW +: CW]), 32'(m_cnt[i]));
`endif
  endtask

  task automatic step1(input int s, input logic [7:0] c);
    logic [8*N-1:0] chars;
    chars = '0;
    chars[8*s +: 8] = c;
    step(1'b0, N'(1 << s), chars, '0, 1'b1);
  endtask

  task automatic rst_cycle();
    step(1'b1, '0, '0, '0, 1'b1);
  endtask

  logic [7:0] t1_chars [5];
  logic       t1_exp   [5];
  logic [7:0] t3_chars [5];
  int         t3_src   [5];
  logic       t3_exp   [5];

  initial begin
    logic [8*N-1:0] rc;
    logic [1:0]     held_src;
    logic           held_match;
    t1_chars = '{"a", "b", "1", "2", " "};
    t1_exp   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    t3_chars = '{"x", "7", "9", "q", "5"};
    t3_src   = '{0, 1, 0, 1, 1};
    t3_exp   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    reset = 1'b1; src_valid = '0; src_char = '0; src_clear = '0; res_ready = 1'b1;
    model_reset();

    // Reset state
    rst_cycle();
    tb_check("rst_valid", 32'(res_valid), 32'd0);
    tb_check("rst_src", 32'(res_src), 32'd0);
    tb_check("rst_match", 32'(res_match), 32'd0);

    // Single-source recognition
    for (int i = 0; i < 5; i++) begin
      step1(0, t1_chars[i]);
      tb_check("t1_match", 32'(res_match), 32'(t1_exp[i]));
      tb_check("t1_src", 32'(res_src), 32'd0);
    end

    // Strict rotation with all sources valid
    rst_cycle();
    for (int i = 0; i < 8; i++) begin
      for (int s = 0; s < N; s++) rc[8*s +: 8] = rnd_char();
      step(1'b0, '1, rc, '0, 1'b1);
      tb_check("t2_rot", 32'(res_src), 32'(i % N));
    end

    // Interleaved contexts
    rst_cycle();
    for (int i = 0; i < 5; i++) begin
      step1(t3_src[i], t3_chars[i]);
      tb_check("t3_match", 32'(res_match), 32'(t3_exp[i]));
    end

    // Backpressure hold
    step1(2, "k");
    held_src = res_src; held_match = res_match;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '1, {"9", "9", "9", "9"}, '0, 1'b0);
      tb_check("t4_ready", 32'(last_ready), 32'd0);
      tb_check("t4_src", 32'(res_src), 32'(held_src));
      tb_check("t4_match", 32'(res_match), 32'(held_match));
    end
    step1(2, "4");
    tb_check("t4_resume", 32'(res_match), 32'd1);

    // Clear beats accept
    step1(1, "a");
    step(1'b0, 4'b0010, {8'h0, 8'h0, "3", 8'h0}, 4'b0010, 1'b1);
    tb_check("t5_noacc", 32'(last_ready), 32'd0);
    step1(1, "3");
    tb_check("t5_match", 32'(res_match), 32'd0);

    // Reset mid-stream with a held result
    step1(3, "z");
    step(1'b1, '1, {"1", "1", "1", "1"}, '0, 1'b0);
    tb_check("t6_valid", 32'(res_valid), 32'd0);
    step(1'b0, '1, {"1", "1", "1", "1"}, '0, 1'b1);
    tb_check("t6_rr", 32'(res_src), 32'd0);
    step1(3, "1");
    tb_check("t6_ctx", 32'(res_match), 32'd0);
`ifdef ID_SCAN_MATCH_COUNT_EN
    rst_cycle();
    step1(0, "a");
    for (int i = 0; i < 5; i++) step1(0, "5");
    tb_check("t6_sat", 32'(match_cnt[CW-1:0]), 32'd3);
`endif

    // Randomized traffic
    rst_cycle();
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] v, cl;
      for (int s = 0; s < N; s++) begin
        rc[8*s +: 8] = rnd_char();
        cl[s] = ($urandom_range(0, 15) == 0);
      end
      v = N'($urandom);
      step(($urandom_range(0, 199) == 0), v, rc, cl, ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
